keypad_scanner: RTL and testbench

- Column-scan controller for the 4x3 keypad matrix.
- Drives the one-hot column lines into the keypad / virtual-keypad row-sense stage and reads back its 4 row lines.
- Assembles a 12-key frame per full scan and debounces it over consecutive frames.
- Emits a decoded key code with a one-cycle valid strobe to the lock control logic downstream.

---
 rtl/keypad_scanner.sv | 179 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Column-scan controller for a 4x3 keypad matrix. Drives one column at a time,
// samples the four row lines at the end of each column dwell, assembles a 12-key
// frame per full scan, debounces it over consecutive frames and reports a decoded
// single-key press with a one-cycle strobe.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Row,
  output logic [2:0] Col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_SCANS);

  // Column scan state
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [2:0]      col_q, col_d;

  // Frame assembly and debounce state
  logic [11:0]     frame_q, frame_d;
  logic [11:0]     cand_q, cand_d;
  logic [CntW-1:0] match_q, match_d;
  logic [11:0]     stable_q, stable_d;
  logic            accept_q, accept_d;

  // Output registers
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            multi_key_q, multi_key_d;

  logic            sample;
  logic            frame_last;
  logic [3:0]      cand_pop;

  // Number of pressed keys in a frame.
  function automatic logic [3:0] popcount12(input logic [11:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 12; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Index of the lowest set bit; only meaningful for a one-hot frame.
  function automatic logic [3:0] key_index(input logic [11:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  assign sample     = (div_q == DivLast);
  assign frame_last = sample && (col_idx_q == 2'd2);
  assign cand_pop   = popcount12(cand_q);

  // Dwell counter and column rotation; the column only moves on a sample edge.
  always_comb begin
    div_d     = div_q;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    if (sample) begin
      div_d     = '0;
      col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      col_d     = {col_q[1:0], col_q[2]};
    end else begin
      div_d = div_q + DivW'(1);
    end
  end

  // Write the sampled rows of the current column into the frame buffer.
  always_comb begin
    frame_d = frame_q;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 3; c++) begin
          if (col_idx_q == 2'(c)) begin
            frame_d[3*r+c] = Row[r];
          end
        end
      end
    end
  end

  // Debounce: count consecutive identical frames, flag a new stable frame.
  always_comb begin
    cand_d   = cand_q;
    match_d  = match_q;
    accept_d = 1'b0;
    if (frame_last) begin
      if (frame_d != cand_q) begin
        cand_d  = frame_d;
        match_d = CntW'(1);
      end else if (match_q != CntMax) begin
        match_d = match_q + CntW'(1);
      end
      accept_d = (match_d == CntMax) && (cand_d != stable_q);
    end
  end

  // Apply an accepted frame: all outputs move together one edge after acceptance.
  always_comb begin
    stable_d    = stable_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    if (accept_q) begin
      stable_d    = cand_q;
      key_held_d  = (cand_pop == 4'd1);
      multi_key_d = (cand_pop >= 4'd2);
      // Strobe only on a fresh press from an empty keypad.
      if ((stable_q == 12'd0) && (cand_pop == 4'd1)) begin
        key_code_d  = key_index(cand_q);
        key_valid_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 3'b001;
      frame_q     <= 12'd0;
      cand_q      <= 12'd0;
      match_q     <= '0;
      stable_q    <= 12'd0;
      accept_q    <= 1'b0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      frame_q     <= frame_d;
      cand_q      <= cand_d;
      match_q     <= match_d;
      stable_q    <= stable_d;
      accept_q    <= accept_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign Col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

  // Column drive must always be exactly one-hot.
  a_col_onehot : assert property (@(posedge clock) disable iff (reset) $onehot(Col));

  // Accepted frames are at least a frame apart, so the strobe never repeats.
  a_valid_single : assert property (@(posedge clock) disable iff (reset)
                                    key_valid |=> !key_valid);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a frame-level keypad model predicts every output on
// every cycle, and directed literal checks pin the key timing points.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int FP  = 3 * SD;

  logic       clock;
  logic       reset;
  logic [3:0] Row;
  logic [2:0] Col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  logic [11:0] pressed;

  int checks;
  int fails;
  int strobes;
  bit started;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .Row      (Row),
    .Col      (Col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_key(multi_key)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad matrix: a row reads 1 if a pressed key of that row sits on a driven column.
  always_comb begin
    Row = 4'd0;
    for (int r = 0; r < 4; r++) begin
      Row[r] = |(Col & pressed[3*r +: 3]);
    end
  end

  // ---------------- behavioural model ----------------
  int          m_cycle;
  logic [11:0] m_frame;
  logic [11:0] m_stable;
  logic [11:0] m_pend;
  bit          m_pend_v;
  logic [11:0] m_hist[$];
  logic [3:0]  e_code;
  bit          e_valid;
  bit          e_held;
  bit          e_multi;

  function automatic int lowest(input logic [11:0] v);
    for (int i = 0; i < 12; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    bit same;
    int col;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_cycle = 0; m_frame = 0; m_stable = 0; m_pend = 0; m_pend_v = 0;
        m_hist.delete();
        e_code = 0; e_valid = 0; e_held = 0; e_multi = 0;
      end else begin
        e_valid = 0;
        if (m_pend_v) begin
          e_held  = ($countones(m_pend) == 1);
          e_multi = ($countones(m_pend) >= 2);
          if (m_stable == 0 && $countones(m_pend) == 1) begin
            e_code  = 4'(lowest(m_pend));
            e_valid = 1;
          end
          m_stable = m_pend;
          m_pend_v = 0;
        end
        m_cycle++;
        if (m_cycle % SD == 0) begin
          col = ((m_cycle / SD) - 1) % 3;
          for (int r = 0; r < 4; r++) m_frame[3*r+col] = pressed[3*r+col];
          if (col == 2) begin
            m_hist.push_back(m_frame);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            same = (m_hist.size() == DEB);
            foreach (m_hist[i]) if (m_hist[i] != m_frame) same = 0;
            if (same && m_frame != m_stable) begin
              m_pend   = m_frame;
              m_pend_v = 1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    logic [2:0] e_col;
    forever begin
      @(negedge clock);
      if (started) begin
        e_col = 3'b001 << ((m_cycle / SD) % 3);
        check("col", 32'(Col), 32'(e_col));
        check("key_code", 32'(key_code), 32'(e_code));
        check("key_valid", 32'(key_valid), 32'(e_valid));
        check("key_held", 32'(key_held), 32'(e_held));
        check("multi_key", 32'(multi_key), 32'(e_multi));
        if (key_valid === 1'b1) strobes++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic align_frame();
    int guard;
    guard = 0;
    while ((m_cycle % FP) != 0 && guard < FP) begin
      step(1);
      guard++;
    end
    check("frame_align", 32'((m_cycle % FP) == 0), 32'd1);
  endtask

  initial begin
    int base;
    checks = 0; fails = 0; strobes = 0; started = 0;
    reset = 1'b1;
    pressed = 12'd0;

    // 1. Reset defaults and idle scan
    step(3);
    started = 1;
    check("rst_col", 32'(Col), 32'h1);
    check("rst_outs", 32'({key_code, key_valid, key_held, multi_key}), 32'h0);
    reset = 1'b0;
    step(3);  check("idle_col_e3", 32'(Col), 32'h1);
    step(1);  check("idle_col_e4", 32'(Col), 32'h2);
    step(4);  check("idle_col_e8", 32'(Col), 32'h4);
    step(4);  check("idle_col_e12", 32'(Col), 32'h1);
    step(3 * FP);
    check("idle_outs", 32'({key_code, key_valid, key_held, multi_key}), 32'h0);

    // 2. Single press of key 4 held from reset release
    reset = 1'b1;
    step(2);
    pressed = 12'd1 << 4;
    reset = 1'b0;
    base = strobes;
    step(36); check("k4_e36_valid", 32'(key_valid), 32'd0);
    step(1);  check("k4_e37_valid", 32'(key_valid), 32'd1);
    check("k4_code", 32'(key_code), 32'd4);
    check("k4_held", 32'(key_held), 32'd1);
    check("k4_multi", 32'(multi_key), 32'd0);
    step(1);  check("k4_e38_valid", 32'(key_valid), 32'd0);
    pressed = 12'd0;
    step(4 * FP);
    check("k4_rel_held", 32'(key_held), 32'd0);
    check("k4_rel_code", 32'(key_code), 32'd4);
    check("k4_strobes", 32'(strobes - base), 32'd1);

    // 3. Bounce rejection on key 7, then a steady press
    align_frame();
    base = strobes;
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 1) ? (12'd1 << 7) : 12'd0;
      step(FP);
    end
    check("bounce_strobes", 32'(strobes - base), 32'd0);
    check("bounce_held", 32'(key_held), 32'd0);
    check("bounce_code", 32'(key_code), 32'd4);
    pressed = 12'd1 << 7;
    step(4 * FP);
    check("k7_code", 32'(key_code), 32'd7);
    check("k7_strobes", 32'(strobes - base), 32'd1);

    // 4. Multi-key 0 + 11, then partial and full release
    base = strobes;
    pressed = 12'h801;
    step(4 * FP);
    check("multi_flag", 32'(multi_key), 32'd1);
    check("multi_held", 32'(key_held), 32'd0);
    pressed = 12'h800;
    step(4 * FP);
    check("part_multi", 32'(multi_key), 32'd0);
    check("part_held", 32'(key_held), 32'd1);
    check("part_code", 32'(key_code), 32'd7);
    pressed = 12'd0;
    step(4 * FP);
    check("rel_flags", 32'({key_valid, key_held, multi_key}), 32'd0);
    check("multi_strobes", 32'(strobes - base), 32'd0);

    // 5. Every key in turn
    base = strobes;
    for (int k = 0; k < 12; k++) begin
      pressed = 12'd1 << k;
      step(4 * FP);
      check("sweep_code", 32'(key_code), 32'(k));
      check("sweep_strobes", 32'(strobes - base), 32'(k + 1));
      pressed = 12'd0;
      step(4 * FP);
    end

    // 6. Reset during the col-1 dwell of the second frame of a key 9 press
    align_frame();
    pressed = 12'd1 << 9;
    step(FP + SD + 1);
    reset = 1'b1;
    step(1);
    check("mid_rst_col", 32'(Col), 32'h1);
    check("mid_rst_outs", 32'({key_code, key_valid, key_held, multi_key}), 32'h0);
    reset = 1'b0;
    step(36); check("k9_e36_valid", 32'(key_valid), 32'd0);
    step(1);  check("k9_e37_valid", 32'(key_valid), 32'd1);
    check("k9_code", 32'(key_code), 32'd9);
    step(2 * FP);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
